rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (A3/WD3/WE) between two writeback requesters, e.g. ALU writeback and load writeback.
- Uses round-robin arbitration with a valid/ready handshake and drives the RF write port from registers.
- Contains an init sequencer that zero-fills every register after reset or on a clear command, before normal traffic is admitted.

---
 rtl/rf_write_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter sharing one register-file write port
//               between two writeback requesters, with a zero-fill sweep
//               after reset or clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int DROP_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              init_done,
    output logic              last_grant,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NREG - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_idx;
    logic                r_rf_we;
    logic [ADDR_W-1:0]   r_rf_a3;
    logic [DATA_W-1:0]   r_rf_wd3;
    logic                r_last_grant;
    logic [15:0]         r_stall_cnt;

    logic                w_ready0;
    logic                w_ready1;
    logic                w_accept;
    logic                w_stall;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    // Grant goes to the requester that did not win last; clr blocks all grants.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (r_state == S_RUN && !clr) begin
            w_ready0 = req0_valid && (!req1_valid || r_last_grant);
            w_ready1 = req1_valid && (!req0_valid || !r_last_grant);
        end
    end

    assign w_accept   = w_ready0 | w_ready1;
    assign w_stall    = (req0_valid & ~w_ready0) | (req1_valid & ~w_ready1);
    assign w_sel_addr = w_ready1 ? req1_addr : req0_addr;
    assign w_sel_data = w_ready1 ? req1_data : req0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_INIT;
            r_init_idx   <= '0;
            r_rf_we      <= 1'b0;
            r_rf_a3      <= '0;
            r_rf_wd3     <= '0;
            r_last_grant <= 1'b1;
            r_stall_cnt  <= '0;
        end else begin
            r_rf_we <= 1'b0;

            if (r_state == S_RUN && w_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end

            if (clr) begin
                r_state    <= S_INIT;
                r_init_idx <= '0;
            end else begin
                case (r_state)
                    S_INIT: begin
                        r_rf_we    <= 1'b1;
                        r_rf_a3    <= r_init_idx;
                        r_rf_wd3   <= '0;
                        r_init_idx <= r_init_idx + 1'b1;
                        if (r_init_idx == c_LAST_IDX) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            // Writes to x0 are consumed but never reach the RF.
                            r_rf_we      <= !((DROP_ZERO != 0) && (w_sel_addr == '0));
                            r_rf_a3      <= w_sel_addr;
                            r_rf_wd3     <= w_sel_data;
                            r_last_grant <= w_ready1;
                        end
                    end
                    default: begin
                        r_state <= S_INIT;
                    end
                endcase
            end
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign rf_we      = r_rf_we;
    assign rf_a3      = r_rf_a3;
    assign rf_wd3     = r_rf_wd3;
    assign init_done  = (r_state == S_RUN);
    assign last_grant = r_last_grant;
    assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed, table-driven bench for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        init_done;
    logic        last_grant;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_model [32];

    rf_write_arbiter #(
        .ADDR_W   (5),
        .DATA_W   (32),
        .NREG     (32),
        .DROP_ZERO(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .init_done (init_done),
        .last_grant(last_grant),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the DUT write port; starts with non-zero junk.
    initial begin
        for (int k = 0; k < 32; k++) rf_model[k] = 32'hFFFF_FFFF;
    end
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_a3] <= rf_wd3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        er0;
        logic        er1;
        logic        ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd3;
        logic        elg;
        logic [15:0] estall;
    } vec_t;

    vec_t vecs [10];

    initial begin
        //          v0  a0  d0            v1  a1  d1            r0  r1  we  a3  wd3           lg  stall
        vecs[0] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 1'b0, 5'd31, 32'h0,     1'b1, 16'd0};
        vecs[1] = '{1'b1, 5'd6, 32'h2,     1'b0, 5'd0, 32'h0,     1'b1, 1'b0, 1'b1, 5'd6,  32'h2,     1'b0, 16'd0};
        vecs[2] = '{1'b1, 5'd8, 32'h5,     1'b1, 5'd9, 32'h7,     1'b0, 1'b1, 1'b1, 5'd9,  32'h7,     1'b1, 16'd1};
        vecs[3] = '{1'b1, 5'd8, 32'h5,     1'b0, 5'd9, 32'h7,     1'b1, 1'b0, 1'b1, 5'd8,  32'h5,     1'b0, 16'd1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 1'b0, 5'd8,  32'h5,     1'b0, 16'd1};
        vecs[5] = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 32'hDEAD,  1'b0, 1'b1, 1'b0, 5'd0,  32'hDEAD,  1'b1, 16'd1};
        vecs[6] = '{1'b1, 5'd3, 32'h33,    1'b1, 5'd4, 32'h44,    1'b1, 1'b0, 1'b1, 5'd3,  32'h33,    1'b0, 16'd2};
        vecs[7] = '{1'b1, 5'd5, 32'h55,    1'b1, 5'd4, 32'h44,    1'b0, 1'b1, 1'b1, 5'd4,  32'h44,    1'b1, 16'd3};
        vecs[8] = '{1'b1, 5'd5, 32'h55,    1'b0, 5'd0, 32'h0,     1'b1, 1'b0, 1'b1, 5'd5,  32'h55,    1'b0, 16'd3};
        vecs[9] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 1'b0, 5'd5,  32'h55,    1'b0, 16'd3};

        reset = 1'b0;
        clr = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h2;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;

        // Reset values, with a request already pending.
        tick();
        tick();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_a3", 32'(rf_a3), 32'd0);
        chk("rst_wd3", rf_wd3, 32'd0);
        chk("rst_lg", 32'(last_grant), 32'd1);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        #2;
        reset = 1'b1;

        // Zero-fill sweep: 32 writes, readys held low, stall frozen.
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("init_we", 32'(rf_we), 32'd1);
            chk("init_a3", 32'(rf_a3), 32'(i));
            chk("init_wd3", rf_wd3, 32'd0);
            chk("init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) begin
                chk("init_ready0", 32'(req0_ready), 32'd0);
                chk("init_stall", 32'(stall_cnt), 32'd0);
            end
        end
        req0_valid = 1'b0;
        tick();
        chk("rf_read7", rf_model[7], 32'd0);
        chk("rf_read31", rf_model[31], 32'd0);
        chk("idle_we", 32'(rf_we), 32'd0);

        // Normal traffic table.
        for (int v = 0; v < 10; v++) begin
            req0_valid = vecs[v].v0; req0_addr = vecs[v].a0; req0_data = vecs[v].d0;
            req1_valid = vecs[v].v1; req1_addr = vecs[v].a1; req1_data = vecs[v].d1;
            #1;
            chk($sformatf("v%0d_ready0", v), 32'(req0_ready), 32'(vecs[v].er0));
            chk($sformatf("v%0d_ready1", v), 32'(req1_ready), 32'(vecs[v].er1));
            tick();
            chk($sformatf("v%0d_we", v), 32'(rf_we), 32'(vecs[v].ewe));
            chk($sformatf("v%0d_a3", v), 32'(rf_a3), 32'(vecs[v].ea3));
            chk($sformatf("v%0d_wd3", v), rf_wd3, vecs[v].ewd3);
            chk($sformatf("v%0d_lg", v), 32'(last_grant), 32'(vecs[v].elg));
            chk($sformatf("v%0d_stall", v), 32'(stall_cnt), 32'(vecs[v].estall));
        end
        chk("rf_reg6", rf_model[6], 32'h2);
        chk("rf_reg8", rf_model[8], 32'h5);
        chk("rf_reg9", rf_model[9], 32'h7);
        chk("rf_reg0", rf_model[0], 32'h0);
        chk("rf_reg3", rf_model[3], 32'h33);
        chk("rf_reg4", rf_model[4], 32'h44);
        chk("rf_reg5", rf_model[5], 32'h55);

        // clr with a pending request: blocked, sweep, then accepted.
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h88;
        clr = 1'b1;
        #1;
        chk("clr_ready0", 32'(req0_ready), 32'd0);
        tick();
        clr = 1'b0;
        chk("clr_we", 32'(rf_we), 32'd0);
        chk("clr_done", 32'(init_done), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clr_init_a3", 32'(rf_a3), 32'(i));
            chk("clr_init_we", 32'(rf_we), 32'd1);
            if (i < 31) chk("clr_init_ready0", 32'(req0_ready), 32'd0);
            if (i == 9) chk("clr_reg8_zero", rf_model[8], 32'd0);
        end
        chk("clr_lg_kept", 32'(last_grant), 32'd0);
        chk("clr_ready0_run", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("clr_acc_we", 32'(rf_we), 32'd1);
        chk("clr_acc_a3", 32'(rf_a3), 32'd8);
        chk("clr_acc_wd3", rf_wd3, 32'h88);
        tick();
        chk("clr_reg8", rf_model[8], 32'h88);

        // Asynchronous reset in the middle of a sweep.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_a3_11", 32'(rf_a3), 32'd11);
        #3;
        reset = 1'b0;
        #1;
        chk("async_we", 32'(rf_we), 32'd0);
        chk("async_a3", 32'(rf_a3), 32'd0);
        chk("async_lg", 32'(last_grant), 32'd1);
        chk("async_stall", 32'(stall_cnt), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("restart_we", 32'(rf_we), 32'd1);
        chk("restart_a3", 32'(rf_a3), 32'd0);
        tick();
        chk("restart_a3_1", 32'(rf_a3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
